intrusion_detector: RTL and testbench

INTRUSION_DETECTOR -- requirements
Module: intrusion_detector

---
 rtl/intrusion_detector.sv | 168 ++++++++++++++++
 tb/tb_intrusion_detector.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intrusion_detector.sv
// Intrusion detector: synchronised, debounced sensors feeding an alarm FSM.
// Ports: clk, rst (sync active-low), arm/code_ok/code_bad pulses,
//   raw door/window/motion/tamper inputs;
//   intruder_detected, system_compromised, armed (all registered).
module intrusion_detector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EXIT_DELAY      = 16,
  parameter int ENTRY_DELAY     = 16,
  parameter int MAX_FAIL        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic arm,
  input  logic code_ok,
  input  logic code_bad,
  input  logic door_sensor,
  input  logic window_sensor,
  input  logic motion_sensor,
  input  logic tamper,
  output logic intruder_detected,
  output logic system_compromised,
  output logic armed
);

  localparam int MAXD = (EXIT_DELAY > ENTRY_DELAY) ?
                        EXIT_DELAY : ENTRY_DELAY;
  localparam int TW = $clog2(MAXD + 1);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    S_DIS,
    S_EXIT,
    S_ARMED,
    S_ENTRY,
    S_ALARM
  } state_e;

  // bit 0 door, 1 window, 2 motion, 3 tamper
  logic [3:0]    raw;
  logic [3:0]    s1_q, s2_q;
  logic [3:0]    deb_q, deb_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [FW-1:0] fail_q, fail_d;
  logic          comp_q, comp_d;
  logic          intr_q, armed_q;

  logic ok;
  logic wm;

  assign raw = {tamper, motion_sensor, window_sensor, door_sensor};

  // Count cycles the synced level disagrees with the accepted one;
  // any agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A simultaneous bad code overrides a good one.
  assign ok = code_ok & ~code_bad;
  assign wm = deb_q[1] | deb_q[2];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      S_DIS: begin
        if (arm && !ok) begin
          state_d = S_EXIT;
          timer_d = TW'(EXIT_DELAY);
        end
      end
      S_EXIT: begin
        if (ok) begin
          state_d = S_DIS;
        end else if (timer_q <= TW'(1)) begin
          state_d = S_ARMED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_ARMED: begin
        if (ok) begin
          state_d = S_DIS;
        end else if (wm) begin
          state_d = S_ALARM;
        end else if (deb_q[0]) begin
          state_d = S_ENTRY;
          timer_d = TW'(ENTRY_DELAY);
        end
      end
      S_ENTRY: begin
        if (ok) begin
          state_d = S_DIS;
        end else if (wm || timer_q <= TW'(1)) begin
          state_d = S_ALARM;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_ALARM: begin
        if (ok) state_d = S_DIS;
      end
      default: begin
        state_d = S_DIS;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    fail_d = fail_q;
    if (code_bad) begin
      if (fail_q != FW'(MAX_FAIL)) fail_d = fail_q + 1'b1;
    end else if (code_ok) begin
      fail_d = '0;
    end
    comp_d = comp_q | (fail_q == FW'(MAX_FAIL)) | deb_q[3];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      state_q <= S_DIS;
      timer_q <= '0;
      fail_q  <= '0;
      comp_q  <= 1'b0;
      intr_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      comp_q  <= comp_d;
      intr_q  <= (state_d == S_ALARM);
      armed_q <= (state_d != S_DIS);
    end
  end

  assign intruder_detected  = intr_q;
  assign system_compromised = comp_q;
  assign armed              = armed_q;

endmodule

// File: tb/tb_intrusion_detector.sv
// Scoreboard bench for intrusion_detector: reference model pushes
// expected outputs per edge, a negedge monitor pops and compares.
module tb_intrusion_detector;

  localparam int DB    = 4;
  localparam int EXITD = 16;
  localparam int ENTD  = 16;
  localparam int MAXF  = 3;

  localparam int M_DIS   = 0;
  localparam int M_EXIT  = 1;
  localparam int M_ARMED = 2;
  localparam int M_ENTRY = 3;
  localparam int M_ALARM = 4;

  logic clk;
  logic rst;
  logic arm;
  logic code_ok;
  logic code_bad;
  logic door_sensor;
  logic window_sensor;
  logic motion_sensor;
  logic tamper;
  logic intruder_detected;
  logic system_compromised;
  logic armed;

  intrusion_detector #(
    .DEBOUNCE_CYCLES(DB),
    .EXIT_DELAY(EXITD),
    .ENTRY_DELAY(ENTD),
    .MAX_FAIL(MAXF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .code_ok(code_ok),
    .code_bad(code_bad),
    .door_sensor(door_sensor),
    .window_sensor(window_sensor),
    .motion_sensor(motion_sensor),
    .tamper(tamper),
    .intruder_detected(intruder_detected),
    .system_compromised(system_compromised),
    .armed(armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] expq [$];

  // reference model state
  int       m_st = M_DIS;
  int       m_dl = 0;
  int       m_fl = 0;
  bit       m_cp = 0;
  bit [3:0] m_deb = '0;
  bit [5:0] m_h [4];
  int       m_n = 0;
  bit [3:0] sens = '0;

  // Raw history h[s][k] = raw level k edges ago; a debounced level
  // flips once the synced samples (2..5 edges old) all disagree.
  task automatic mdl();
    bit ok;
    bit [3:0] dold;
    bit [3:0] rv;
    bit all;
    m_n++;
    rv = {tamper, motion_sensor, window_sensor, door_sensor};
    if (!rst) begin
      m_st = M_DIS;
      m_fl = 0;
      m_cp = 0;
      m_deb = '0;
      for (int s = 0; s < 4; s++) m_h[s] = '0;
    end else begin
      ok = code_ok && !code_bad;
      dold = m_deb;
      for (int s = 0; s < 4; s++) begin
        m_h[s] = {m_h[s][4:0], rv[s]};
        all = 1;
        for (int k = 2; k < 2 + DB; k++)
          if (m_h[s][k] == m_deb[s]) all = 0;
        if (all) m_deb[s] = ~m_deb[s];
      end
      m_cp = m_cp | (m_fl == MAXF) | dold[3];
      if (code_bad) m_fl = (m_fl < MAXF) ? m_fl + 1 : MAXF;
      else if (ok) m_fl = 0;
      case (m_st)
        M_DIS:
          if (arm && !ok) begin
            m_st = M_EXIT;
            m_dl = m_n + EXITD;
          end
        M_EXIT:
          if (ok) m_st = M_DIS;
          else if (m_n == m_dl) m_st = M_ARMED;
        M_ARMED:
          if (ok) m_st = M_DIS;
          else if (dold[1] || dold[2]) m_st = M_ALARM;
          else if (dold[0]) begin
            m_st = M_ENTRY;
            m_dl = m_n + ENTD;
          end
        M_ENTRY:
          if (ok) m_st = M_DIS;
          else if (dold[1] || dold[2] || m_n == m_dl) m_st = M_ALARM;
        default:
          if (ok) m_st = M_DIS;
      endcase
    end
    expq.push_back({m_st == M_ALARM, m_cp, m_st != M_DIS});
  endtask

  task automatic step(input bit r, input bit a, input bit ok,
                      input bit bad);
    rst = r;
    arm = a;
    code_ok = ok;
    code_bad = bad;
    {tamper, motion_sensor, window_sensor, door_sensor} = sens;
    mdl();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    logic [2:0] g;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      g = {intruder_detected, system_compromised, armed};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t {intr,comp,armed} got %b exp %b",
                 $time, g, e);
      end
    end
  end

  initial begin
    int lat;
    rst = 0; arm = 0; code_ok = 0; code_bad = 0;
    {tamper, motion_sensor, window_sensor, door_sensor} = '0;

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    idle(2);

    // arm, exit delay, ARMED
    step(1, 1, 0, 0);
    idle(20);

    // motion held: alarm 7 edges after the raw edge
    sens[2] = 1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0, 0);
      if (intruder_detected && lat == 0) lat = i;
    end
    vectors++;
    if (lat != 2 + DB + 1) begin
      miscompares++;
      $display("FAIL motion_latency got %0d exp %0d", lat, 2 + DB + 1);
    end
    sens[2] = 0;
    idle(3);
    step(1, 0, 1, 0);
    idle(10);

    // 3-cycle motion glitch while armed
    step(1, 1, 0, 0);
    idle(20);
    sens[2] = 1;
    idle(3);
    sens[2] = 0;
    idle(15);

    // door, disarm at cycle 10 of entry delay
    sens[0] = 1;
    idle(7 + 9);
    step(1, 0, 1, 0);
    sens[0] = 0;
    idle(10);
    // door again, no code: alarm after entry delay
    step(1, 1, 0, 0);
    idle(20);
    sens[0] = 1;
    idle(30);
    sens[0] = 0;
    idle(5);
    step(1, 0, 1, 0);
    idle(3);

    // arm+code_ok together stays disarmed; ok+bad counts as bad
    step(1, 1, 1, 0);
    step(1, 0, 1, 1);
    idle(2);
    step(0, 0, 0, 0);

    // three bad codes -> compromised, survives code_ok
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    idle(3);
    step(1, 0, 1, 0);
    idle(3);
    step(0, 0, 0, 0);
    idle(3);

    // tamper, then alarm, then reset in ALARM
    sens[3] = 1;
    idle(10);
    sens[3] = 0;
    step(1, 1, 0, 0);
    idle(20);
    sens[1] = 1;
    idle(10);
    step(0, 0, 0, 0);
    sens[1] = 0;
    idle(8);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) sens[0] = ~sens[0];
      if ($urandom_range(0, 14) == 0) sens[1] = ~sens[1];
      if ($urandom_range(0, 14) == 0) sens[2] = ~sens[2];
      if ($urandom_range(0, 299) == 0) sens[3] = ~sens[3];
      step($urandom_range(0, 149) != 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 59) == 0);
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    if (expq.size() > 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending exp 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
